// File: rtl/yacht_pkg.sv
// Shared definitions for the Yacht game controller: FSM state encoding and
// upper-section bonus constants.
package yacht_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TURN_START = 3'd1,
    S_FIRST_ROLL = 3'd2,
    S_SELECT     = 3'd3,
    S_COMMIT     = 3'd4,
    S_OVER       = 3'd5
  } state_t;

  localparam int UPPER_CNT          = 6;
  localparam int UPPER_BONUS_THRESH = 63;
  localparam int UPPER_BONUS_VAL    = 35;

endpackage

// File: rtl/yacht_game_ctrl_free_cat_finder.sv
// Combinational search for the nearest unused category from cur_idx,
// stepping up or down with wrap-around; returns cur_idx when nothing is free.
module free_cat_finder
  import yacht_pkg::*;
#(
  parameter int NUM_CATEGORIES = 12,
  parameter int CW             = $clog2(NUM_CATEGORIES)
) (
  input  logic [NUM_CATEGORIES-1:0] used,
  input  logic [CW-1:0]             cur_idx,
  input  logic                      dir_up,
  output logic [CW-1:0]             nxt_idx,
  output logic                      found
);

  int          cand;
  logic [CW-1:0] cand_idx;

  // Scan from the farthest offset inward so the nearest free slot wins;
  // offset NUM_CATEGORIES lands back on cur_idx itself.
  always_comb begin
    nxt_idx  = cur_idx;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_CATEGORIES; k >= 1; k--) begin
      if (dir_up) begin
        cand = (int'(cur_idx) + k) % NUM_CATEGORIES;
      end else begin
        cand = (int'(cur_idx) + NUM_CATEGORIES - k) % NUM_CATEGORIES;
      end
      cand_idx = CW'(cand);
      if (!used[cand_idx]) begin
        nxt_idx = cand_idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yacht_game_ctrl.sv
// N-player Yacht turn/round/score controller. Optional upper-section bonus
// is enabled by defining YACHT_UPPER_BONUS_EN.
module yacht_game_ctrl
  import yacht_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_CATEGORIES = 12,
  parameter int NUM_ROUNDS     = 12,
  parameter int MAX_ROLLS      = 3,
  parameter int SCORE_W        = 8,
  parameter int TOT_W          = 10,
  localparam int PW            = $clog2(NUM_PLAYERS),
  localparam int CW            = $clog2(NUM_CATEGORIES)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      roll_btn,
  input  logic                      sel_btn,
  input  logic                      prev_btn,
  input  logic                      next_btn,
  input  logic [SCORE_W-1:0]        calc_score,
  input  logic [PW-1:0]             score_rd_idx,
  output logic                      roll_trigger,
  output logic                      clear_dice,
  output logic [CW-1:0]             category_idx,
  output logic [PW-1:0]             player_idx,
  output logic [3:0]                round_num,
  output logic [1:0]                rolls_left,
  output logic [2:0]                state,
  output logic [NUM_CATEGORIES-1:0] used_mask,
  output logic [TOT_W-1:0]          score_rd_data,
`ifdef YACHT_UPPER_BONUS_EN
  output logic [NUM_PLAYERS-1:0]    upper_bonus,
`endif
  output logic                      game_over,
  output logic [PW-1:0]             winner_idx,
  output logic                      tie
);

  localparam int SUM_W = ((TOT_W > SCORE_W) ? TOT_W : SCORE_W) + 2;

  if (NUM_ROUNDS > NUM_CATEGORIES) begin : g_bad_rounds
    $error("yacht_game_ctrl: NUM_ROUNDS must not exceed NUM_CATEGORIES");
  end
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || MAX_ROLLS < 1 || MAX_ROLLS > 3) begin : g_bad_params
    $error("yacht_game_ctrl: NUM_PLAYERS must be 2..4 and MAX_ROLLS 1..3");
  end

  // Button order in these vectors is {sel, roll, next, prev}.
  logic [3:0] btn_raw, btn_q_reg, btn_q2_reg, btn_rise;
  logic       armed_reg;
  logic       sel_evt, roll_evt, next_evt, prev_evt;

  state_t                                      state_reg, state_next;
  logic [1:0]                                  rolls_reg, rolls_next;
  logic [CW-1:0]                               cat_reg, cat_next;
  logic [PW-1:0]                               player_reg, player_next;
  logic [3:0]                                  round_reg, round_next;
  logic                                        roll_trig_reg, roll_trig_next;
  logic [NUM_PLAYERS-1:0][TOT_W-1:0]           total_reg, total_next;
  logic [NUM_PLAYERS-1:0][NUM_CATEGORIES-1:0]  used_reg, used_next;
  logic [PW-1:0]                               winner_reg, win_c;
  logic                                        tie_reg, tie_c;
  logic [TOT_W-1:0]                            best;
  logic                                        start_game, commit, win_load;
  logic [CW-1:0]                               lo_idx, nx_idx, pv_idx;
  logic                                        lo_found, nx_found, pv_found;
  logic [NUM_CATEGORIES-1:0]                   cur_used;

  assign btn_raw = {sel_btn, roll_btn, next_btn, prev_btn};

  // The first sample after reset loads both stages so a held level is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q_reg  <= '0;
      btn_q2_reg <= '0;
      armed_reg  <= 1'b0;
    end else begin
      btn_q_reg  <= btn_raw;
      btn_q2_reg <= armed_reg ? btn_q_reg : btn_raw;
      armed_reg  <= 1'b1;
    end
  end

  assign btn_rise = btn_q_reg & ~btn_q2_reg;
  assign sel_evt  = btn_rise[3];
  assign roll_evt = btn_rise[2] & ~btn_rise[3];
  assign next_evt = btn_rise[1] & ~(|btn_rise[3:2]);
  assign prev_evt = btn_rise[0] & ~(|btn_rise[3:1]);

  assign cur_used = used_reg[player_reg];
  assign commit   = (state_reg == S_COMMIT);

  free_cat_finder #(.NUM_CATEGORIES(NUM_CATEGORIES)) u_lowest (
    .used(cur_used), .cur_idx(CW'(NUM_CATEGORIES - 1)), .dir_up(1'b1),
    .nxt_idx(lo_idx), .found(lo_found)
  );
  free_cat_finder #(.NUM_CATEGORIES(NUM_CATEGORIES)) u_next (
    .used(cur_used), .cur_idx(cat_reg), .dir_up(1'b1),
    .nxt_idx(nx_idx), .found(nx_found)
  );
  free_cat_finder #(.NUM_CATEGORIES(NUM_CATEGORIES)) u_prev (
    .used(cur_used), .cur_idx(cat_reg), .dir_up(1'b0),
    .nxt_idx(pv_idx), .found(pv_found)
  );

`ifdef YACHT_UPPER_BONUS_EN
  logic [NUM_PLAYERS-1:0][TOT_W-1:0] sub_reg, sub_next;
  logic [NUM_PLAYERS-1:0]            bonus_reg, bonus_next;
`endif

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic             is_cur;
    logic [SUM_W-1:0] bonus_add, sum;
    assign is_cur = commit && (player_reg == PW'(gi));
`ifdef YACHT_UPPER_BONUS_EN
    logic             is_upper, give_bonus;
    logic [SUM_W-1:0] sub_sum;
    assign is_upper   = int'(cat_reg) < UPPER_CNT;
    assign sub_sum    = SUM_W'(sub_reg[gi]) + SUM_W'(calc_score);
    assign give_bonus = is_cur && is_upper && !bonus_reg[gi] &&
                        (sub_sum >= SUM_W'(UPPER_BONUS_THRESH));
    assign bonus_add  = give_bonus ? SUM_W'(UPPER_BONUS_VAL) : '0;
    assign sub_next[gi] = start_game ? '0 :
                          (is_cur && is_upper) ?
                            ((|sub_sum[SUM_W-1:TOT_W]) ? {TOT_W{1'b1}} : sub_sum[TOT_W-1:0]) :
                            sub_reg[gi];
    assign bonus_next[gi] = start_game ? 1'b0 : (bonus_reg[gi] | give_bonus);
`else
    assign bonus_add = '0;
`endif
    assign sum = SUM_W'(total_reg[gi]) + SUM_W'(calc_score) + bonus_add;
    assign total_next[gi] = start_game ? '0 :
                            is_cur ? ((|sum[SUM_W-1:TOT_W]) ? {TOT_W{1'b1}} : sum[TOT_W-1:0]) :
                            total_reg[gi];
    assign used_next[gi]  = start_game ? '0 :
                            is_cur ? (used_reg[gi] | (NUM_CATEGORIES'(1) << cat_reg)) :
                            used_reg[gi];
  end

  // Winner is judged on post-commit totals so it is valid on the first S_OVER cycle.
  always_comb begin
    win_c = '0;
    tie_c = 1'b0;
    best  = total_next[0];
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (total_next[p] > best) begin
        best  = total_next[p];
        win_c = PW'(p);
        tie_c = 1'b0;
      end else if (total_next[p] == best) begin
        tie_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    rolls_next     = rolls_reg;
    cat_next       = cat_reg;
    player_next    = player_reg;
    round_next     = round_reg;
    roll_trig_next = 1'b0;
    start_game     = 1'b0;
    win_load       = 1'b0;
    case (state_reg)
      S_IDLE, S_OVER: begin
        if (roll_evt) begin
          start_game = 1'b1;
          state_next = S_TURN_START;
        end
      end
      S_TURN_START: begin
        rolls_next = 2'(MAX_ROLLS);
        cat_next   = lo_found ? lo_idx : '0;
        state_next = S_FIRST_ROLL;
      end
      S_FIRST_ROLL: begin
        if (roll_evt) begin
          roll_trig_next = 1'b1;
          rolls_next     = rolls_reg - 2'd1;
          state_next     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_evt) begin
          state_next = S_COMMIT;
        end else if (roll_evt && rolls_reg != 2'd0) begin
          roll_trig_next = 1'b1;
          rolls_next     = rolls_reg - 2'd1;
        end else if (next_evt && nx_found) begin
          cat_next = nx_idx;
        end else if (prev_evt && pv_found) begin
          cat_next = pv_idx;
        end
      end
      S_COMMIT: begin
        if (player_reg == PW'(NUM_PLAYERS - 1) && round_reg == 4'(NUM_ROUNDS)) begin
          win_load   = 1'b1;
          state_next = S_OVER;
        end else begin
          if (player_reg == PW'(NUM_PLAYERS - 1)) begin
            player_next = '0;
            round_next  = round_reg + 4'd1;
          end else begin
            player_next = player_reg + PW'(1);
          end
          state_next = S_TURN_START;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (start_game) begin
      player_next = '0;
      round_next  = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rolls_reg     <= '0;
      cat_reg       <= '0;
      player_reg    <= '0;
      round_reg     <= 4'd1;
      roll_trig_reg <= 1'b0;
      total_reg     <= '0;
      used_reg      <= '0;
      winner_reg    <= '0;
      tie_reg       <= 1'b0;
    end else begin
      rolls_reg     <= rolls_next;
      cat_reg       <= cat_next;
      player_reg    <= player_next;
      round_reg     <= round_next;
      roll_trig_reg <= roll_trig_next;
      total_reg     <= total_next;
      used_reg      <= used_next;
      if (start_game) begin
        winner_reg <= '0;
        tie_reg    <= 1'b0;
      end else if (win_load) begin
        winner_reg <= win_c;
        tie_reg    <= tie_c;
      end
    end
  end

`ifdef YACHT_UPPER_BONUS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_reg   <= '0;
      bonus_reg <= '0;
    end else begin
      sub_reg   <= sub_next;
      bonus_reg <= bonus_next;
    end
  end
  assign upper_bonus = bonus_reg;
`endif

  assign roll_trigger  = roll_trig_reg;
  assign clear_dice    = (state_reg == S_TURN_START);
  assign category_idx  = cat_reg;
  assign player_idx    = player_reg;
  assign round_num     = round_reg;
  assign rolls_left    = rolls_reg;
  assign state         = state_reg;
  assign used_mask     = cur_used;
  assign score_rd_data = (int'(score_rd_idx) < NUM_PLAYERS) ? total_reg[score_rd_idx] : '0;
  assign game_over     = (state_reg == S_OVER);
  assign winner_idx    = winner_reg;
  assign tie           = tie_reg;

endmodule
